// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer
//   Iterative MIPS MULT/MULTU/DIV/DIVU unit that owns the HI/LO registers.
//   A one-cycle StartE launches a radix-2 shift-add multiply or a restoring
//   divide that runs WIDTH iterations, followed by a sign-fix cycle and a
//   one-cycle DONE state. The result lands in HI/LO at the FIX->DONE edge.
//
// Ports
//   CLK, RST      clock, asynchronous active-high reset
//   StartE        one-cycle start request from Execute (already qualified)
//   OpE[1:0]      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   SrcAE, SrcBE  multiplicand/dividend (rs), multiplier/divisor (rt)
//   HiLoUseD      Decode-stage instruction needs HI/LO or this unit
//   BusyMD        operation in progress (MUL, DIV, FIX)
//   DoneMD        one-cycle pulse, HI/LO hold the new result
//   StallMD       stall request to the hazard unit
//   HiMD, LoMD    HI and LO registers
module mult_div_sequencer #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             StartE,
    input  logic [1:0]       OpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             HiLoUseD,
    output logic             BusyMD,
    output logic             DoneMD,
    output logic             StallMD,
    output logic [WIDTH-1:0] HiMD,
    output logic [WIDTH-1:0] LoMD
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    // Upper accumulator (multiply) or partial remainder (divide); the extra
    // bit holds the carry of the add or the shifted-out bit before compare.
    logic [WIDTH:0]       acc_q, acc_d;
    // Multiplier bits shifting out (multiply) or dividend bits shifting out
    // while quotient bits shift in (divide).
    logic [WIDTH-1:0]     wrk_q, wrk_d;
    logic [WIDTH-1:0]     opb_q, opb_d;
    // Operand signs; forced to 0 for unsigned ops so the fix-up is a no-op.
    logic                 sa_q, sa_d;
    logic                 sb_q, sb_d;
    logic                 div_q, div_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_diff;
    logic [2*WIDTH-1:0]   prod_fix;
    logic                 accept;
    logic                 last_iter;

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v,
                                                    input logic neg);
        return neg ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                       input logic neg);
        return neg ? -v : v;
    endfunction

    assign BusyMD  = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign DoneMD  = (state_q == S_DONE);
    assign StallMD = BusyMD & HiLoUseD;
    assign HiMD    = hi_q;
    assign LoMD    = lo_q;

    // A start is only honoured when no operation is in flight.
    assign accept    = StartE && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_iter = (cnt_q == CNT_WIDTH'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        opb_d   = opb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        mul_sum  = wrk_q[0] ? ({1'b0, acc_q[WIDTH-1:0]} + {1'b0, opb_q})
                            : {1'b0, acc_q[WIDTH-1:0]};
        rem_sh   = {acc_q[WIDTH-1:0], wrk_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, opb_q};
        prod_fix = cond_neg_2w({acc_q[WIDTH-1:0], wrk_q}, sa_q ^ sb_q);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
            end
            S_MUL: begin
                // Shift {carry, sum, multiplier} right by one.
                acc_d = {1'b0, mul_sum[WIDTH:1]};
                wrk_d = {mul_sum[0], wrk_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (last_iter) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_DIV: begin
                if (rem_sh >= {1'b0, opb_q}) begin
                    acc_d = rem_diff;
                    wrk_d = {wrk_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh;
                    wrk_d = {wrk_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (last_iter) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // HI/LO are written only here (and on divide-by-zero), whole.
                if (div_q) begin
                    hi_d = cond_neg_w(acc_q[WIDTH-1:0], sa_q);
                    lo_d = cond_neg_w(wrk_q, sa_q ^ sb_q);
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            sa_d  = OpE[0] & SrcAE[WIDTH-1];
            sb_d  = OpE[0] & SrcBE[WIDTH-1];
            div_d = OpE[1];
            acc_d = '0;
            cnt_d = '0;
            wrk_d = cond_neg_w(SrcAE, OpE[0] & SrcAE[WIDTH-1]);
            opb_d = cond_neg_w(SrcBE, OpE[0] & SrcBE[WIDTH-1]);
            if (OpE[1] && (SrcBE == '0)) begin
                // Divide by zero: no iterations, architecturally defined result.
                hi_d    = SrcAE;
                lo_d    = '1;
                state_d = S_DONE;
            end else if (OpE[1]) begin
                state_d = S_DIV;
            end else begin
                state_d = S_MUL;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            wrk_q   <= '0;
            opb_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wrk_q   <= wrk_d;
            opb_q   <= opb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Testbench for mult_div_sequencer: table of directed operations with
// hand-computed HI/LO and latency, plus stall/ignored-start and
// asynchronous-reset sequences.
module tb_mult_div_sequencer;

    logic        clk;
    logic        rst;
    logic        start_e;
    logic [1:0]  op_e;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        hilo_use;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mult_div_sequencer #(.WIDTH(32), .CNT_WIDTH(6)) dut (
        .CLK     (clk),
        .RST     (rst),
        .StartE  (start_e),
        .OpE     (op_e),
        .SrcAE   (src_a),
        .SrcBE   (src_b),
        .HiLoUseD(hilo_use),
        .BusyMD  (busy),
        .DoneMD  (done),
        .StallMD (stall),
        .HiMD    (hi),
        .LoMD    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Issue one operation and follow it to DoneMD, checking latency, the
    // number of Busy cycles and the HI/LO result.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh,
                          input logic [31:0] el, input int lat);
        int k;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        start_e = 1'b1;
        op_e    = op;
        src_a   = a;
        src_b   = b;
        @(negedge clk);
        start_e  = 1'b0;
        k        = 1;
        busy_cnt = 0;
        seen     = 1'b0;
        while (k <= 60 && !seen) begin
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy === 1'b1) busy_cnt++;
                @(negedge clk);
                k++;
            end
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_latency"}, 32'(k), 32'(lat));
        chk({name, "_busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
        chk({name, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    initial begin
        int stall_bad;

        vecs[0]  = '{"multu_max",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34};
        vecs[1]  = '{"mult_m7x6",  2'b01, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6, 34};
        vecs[2]  = '{"div_m17_5",  2'b11, 32'hFFFFFFEF, 32'h00000005, 32'hFFFFFFFE, 32'hFFFFFFFD, 34};
        vecs[3]  = '{"divu_100_7", 2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       34};
        vecs[4]  = '{"divu_by0",   2'b10, 32'd1234,     32'd0,        32'd1234,     32'hFFFFFFFF, 1};
        vecs[5]  = '{"div_ovf",    2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34};
        vecs[6]  = '{"mult_min2",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34};
        vecs[7]  = '{"multu_sh4",  2'b00, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 34};
        vecs[8]  = '{"div_17_m5",  2'b11, 32'd17,       32'hFFFFFFFB, 32'd2,        32'hFFFFFFFD, 34};
        vecs[9]  = '{"mult_m1m1",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 34};
        vecs[10] = '{"div_m5_by0", 2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1};

        rst      = 1'b1;
        start_e  = 1'b0;
        op_e     = 2'b00;
        src_a    = '0;
        src_b    = '0;
        hilo_use = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat);
        end

        // Stall window with a start arriving mid-operation that must be ignored.
        hilo_use = 1'b1;
        @(negedge clk);
        start_e = 1'b1;
        op_e    = 2'b01;
        src_a   = 32'hFFFFFFFD;
        src_b   = 32'd5;
        @(negedge clk);
        start_e   = 1'b0;
        stall_bad = 0;
        for (int k = 1; k <= 33; k++) begin
            if (stall !== 1'b1) stall_bad++;
            if (k == 10) begin
                start_e = 1'b1;
                op_e    = 2'b00;
                src_a   = 32'd2;
                src_b   = 32'd2;
            end
            @(negedge clk);
            start_e = 1'b0;
        end
        chk("stall_window_bad_cycles", 32'(stall_bad), 32'd0);
        chk("stall_at_done", 32'(stall), 32'd0);
        chk("stall_done_pulse", 32'(done), 32'd1);
        chk("ignored_start_hi", hi, 32'hFFFFFFFF);
        chk("ignored_start_lo", lo, 32'hFFFFFFF1);
        @(negedge clk);
        chk("after_done_pulse", 32'(done), 32'd0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk);
        start_e = 1'b1;
        op_e    = 2'b11;
        src_a   = 32'd1000;
        src_b   = 32'd3;
        @(negedge clk);
        start_e = 1'b0;
        repeat (14) @(negedge clk);
        chk("mid_div_busy", 32'(busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_stall", 32'(stall), 32'd0);
        chk("async_rst_hi", hi, 32'd0);
        chk("async_rst_lo", lo, 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        hilo_use = 1'b0;
        run_op("multu_3x4_post_rst", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
